// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: opcode/funct3 constants, the default
// datapath width and the fetch FSM state type.
package riscv_pkg;

  localparam int XLEN_DEF = 32;

  // Opcodes of the control-flow instructions the fetch stage reacts to
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;

  // Branch flavours resolved against the ALU Zero flag
  localparam logic [2:0] FUNCT3_BNE  = 3'b001;
  localparam logic [2:0] FUNCT3_BGEU = 3'b111;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    DRAIN
  } fetch_state_t;

  // Branch condition from funct3 and Zero; unsupported funct3 never branches
  function automatic logic branch_cond(input logic [2:0] funct3, input logic zero);
    case (funct3)
      FUNCT3_BNE:  branch_cond = !zero;
      FUNCT3_BGEU: branch_cond = zero;
      default:     branch_cond = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_resolve.sv
// Combinational resolution of the execute-stage control bundle into a
// redirect request and its target PC.
// Build option FETCH_MISALIGN_CHK_EN: when undefined, target bit[1] is
// forced to 0 so every redirect stays word aligned; when defined the raw
// target is passed through and fetch_unit flags a misaligned one.
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm_ext,
  input  logic [XLEN-1:0] ex_alu_result,
  output logic            redirect,
  output logic [XLEN-1:0] target
);

  logic [XLEN-1:0] raw_target;

  // Taken decision and target selection; JALR clears bit 0, others wrap mod 2^XLEN
  always_comb begin
    redirect = ex_valid & (ex_jump | ex_jalr | (ex_branch & branch_cond(ex_funct3, ex_zero)));
    if (ex_jalr) raw_target = {ex_alu_result[XLEN-1:1], 1'b0};
    else         raw_target = ex_pc + ex_imm_ext;
`ifdef FETCH_MISALIGN_CHK_EN
    target = raw_target;
`else
    target = {raw_target[XLEN-1:2], 1'b0, raw_target[0]};
`endif
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight, buffers the fetched word for decode and flushes on redirects.
// Build option FETCH_MISALIGN_CHK_EN: a redirect whose target has bit[1]
// set raises a sticky misalign flag and parks the FSM in IDLE.
module fetch_unit
  import riscv_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  output logic            if_valid,
  input  logic            if_ready,
  output logic [31:0]     if_instr,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_pc_plus4,
  input  logic            ex_valid,
  input  logic            ex_branch,
  input  logic            ex_jump,
  input  logic            ex_jalr,
  input  logic [2:0]      ex_funct3,
  input  logic            ex_zero,
  input  logic [XLEN-1:0] ex_pc,
  input  logic [XLEN-1:0] ex_imm_ext,
  input  logic [XLEN-1:0] ex_alu_result,
  output logic            redirect,
  output logic            misalign
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] pc_q, target;
  logic            req_hs, load_if, drop_if, bad_target, park;

  branch_resolve #(.XLEN(XLEN)) u_branch_resolve (
    .ex_valid      (ex_valid),
    .ex_branch     (ex_branch),
    .ex_jump       (ex_jump),
    .ex_jalr       (ex_jalr),
    .ex_funct3     (ex_funct3),
    .ex_zero       (ex_zero),
    .ex_pc         (ex_pc),
    .ex_imm_ext    (ex_imm_ext),
    .ex_alu_result (ex_alu_result),
    .redirect      (redirect),
    .target        (target)
  );

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  assign req_hs         = imem_req_valid & imem_req_ready;

`ifdef FETCH_MISALIGN_CHK_EN
  logic misalign_q;
  assign bad_target = redirect & target[1];
  assign park       = misalign_q;
  assign misalign   = misalign_q;

  // Sticky misaligned-redirect flag, cleared only by reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          misalign_q <= 1'b0;
    else if (bad_target) misalign_q <= 1'b1;
  end
`else
  assign bad_target = 1'b0;
  assign park       = 1'b0;
  assign misalign   = 1'b0;
`endif

  // Next-state logic; a redirect overrides the normal flow of every state
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    state_d = state_q;
    load_if = 1'b0;
    drop_if = 1'b0;
    case (state_q)
      IDLE:  if (!park) state_d = REQ;
      REQ:   if (req_hs) state_d = WAIT;
      WAIT:  if (imem_rsp_valid) begin
               load_if = 1'b1;
               state_d = HOLD;
             end
      HOLD:  if (if_ready) begin
               drop_if = 1'b1;
               state_d = REQ;
             end
      DRAIN: if (imem_rsp_valid) state_d = REQ;
      default: state_d = IDLE;
    endcase
    if (redirect) begin
      load_if = 1'b0;
      case (state_q)
        IDLE, REQ: state_d = req_hs ? DRAIN : REQ;
        WAIT:      state_d = imem_rsp_valid ? REQ : DRAIN;
        HOLD: begin
          drop_if = 1'b1;
          state_d = REQ;
        end
        default: ;
      endcase
      if (bad_target) state_d = IDLE;
    end
  end

  // FSM state and PC registers
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state is updated with non-blocking assignments so all registers sample together.
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
    end else begin
      state_q <= state_d;
      if (redirect)     pc_q <= target;
      else if (load_if) pc_q <= pc_q + XLEN'(4);
    end
  end

  // Output buffer towards decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else if (load_if) begin
      if_valid    <= 1'b1;
      if_instr    <= imem_rsp_data;
      if_pc       <= pc_q;
      if_pc_plus4 <= pc_q + XLEN'(4);
    end else if (drop_if) begin
      if_valid    <= 1'b0;
    end
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage directly upstream of the decoder/control unit. It owns the PC, issues one instruction-memory request at a time over a valid/ready handshake, and presents the fetched word plus its PC to decode over a valid/ready handshake. It also consumes the execute-stage control outputs (Branch, Jump, Jalr, Zero) to resolve the next PC. When control flow changes, it flushes any fetch that is in flight.

Parameters:
XLEN, 32, PC/address width
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
imem_req_valid  out  1  fetch request valid
imem_req_ready  in  1  memory accepts request
imem_req_addr  out  XLEN  fetch address (word aligned)
imem_rsp_valid  in  1  response data valid (one response per accepted request)
imem_rsp_data  in  32  fetched instruction
if_valid  out  1  instruction valid to decode
if_ready  in  1  decode accepts instruction
if_instr  out  32  instruction to decode (opcode = if_instr[6:0], funct3 = if_instr[14:12])
if_pc  out  XLEN  PC of if_instr
if_pc_plus4  out  XLEN  if_pc + 4, used by the PC+4 result path (JAL/JALR)
ex_valid  in  1  execute-stage control bundle valid
ex_branch  in  1  Branch from control unit
ex_jump  in  1  Jump (JAL)
ex_jalr  in  1  Jalr
ex_funct3  in  3  branch funct3
ex_zero  in  1  ALU Zero flag
ex_pc  in  XLEN  PC of the executing instruction
ex_imm_ext  in  XLEN  sign-extended immediate
ex_alu_result  in  XLEN  rs1+imm, used for JALR
redirect  out  1  combinational; 1 = control-flow change this cycle, used to flush downstream
misalign  out  1  misaligned redirect target (optional feature)

Behaviour:
- States: IDLE, REQ, WAIT, HOLD, DRAIN. At most one request outstanding.
- Reset (async, rst_n=0): state=IDLE, pc=RESET_PC, if_valid=0, if_instr=0, if_pc=0, if_pc_plus4=0, imem_req_valid=0, misalign=0. redirect is combinational and is 0 whenever ex_valid=0.
- IDLE -> REQ unconditionally on the first clock after reset release.
- REQ: imem_req_valid=1, imem_req_addr=pc. Both are held stable until imem_req_ready. On handshake -> WAIT.
- WAIT: on imem_rsp_valid, register if_instr=rsp_data, if_pc=pc, if_pc_plus4=pc+4, then set pc<=pc+4, if_valid<=1, and -> HOLD.
- HOLD: if_valid=1, and if_instr/if_pc remain stable until if_ready. On if_ready, set if_valid<=0 and -> REQ. Throughput is one instruction per 3 cycles minimum with a zero-wait memory.
- Taken condition: ex_valid & (ex_jump | ex_jalr | (ex_branch & cond)).
  - cond is !ex_zero for funct3 001 (BNE).
  - cond is ex_zero for funct3 111 (BGEU).
  - cond is 0 for any other funct3.
- Target:
  - ex_jalr: {ex_alu_result[XLEN-1:1],1'b0}.
  - Otherwise: ex_pc+ex_imm_ext, modulo 2^XLEN (wrap-around, no overflow detection).
- On redirect=1: pc<=target. Redirect takes priority over every other event in the same cycle. Per state:
  - IDLE/REQ without handshake this cycle: -> REQ with the new address next cycle. Address change while unaccepted is permitted only via redirect.
  - REQ with handshake this cycle: -> DRAIN.
  - WAIT with rsp_valid this cycle: discard the response, -> REQ.
  - WAIT without rsp_valid: -> DRAIN.
  - HOLD: set if_valid<=0 regardless of if_ready, -> REQ.
  - DRAIN: discard the next response, then -> REQ. A further redirect in DRAIN only updates pc.
- Reset asserted mid-transaction returns everything to reset values. A late imem response arriving in IDLE/REQ is ignored.

Optional Feature:
FETCH_MISALIGN_CHK_EN
- Defined: a redirect target with bit[1]=1 sets misalign<=1 (sticky until reset), and the FSM parks in IDLE with no further requests.
- Undefined: misalign is tied to 0, and target bit[1] is forced to 0.

Decomposition:
- Shared package riscv_pkg:
  - opcode and funct3 constants (FUNCT3_BNE=3'b001, FUNCT3_BGEU=3'b111)
  - XLEN default
  - fetch_state_t enum {IDLE,REQ,WAIT,HOLD,DRAIN}
- Sub-module branch_resolve (combinational): computes redirect and target from the ex_* inputs. The FSM, PC and output buffer stay in fetch_unit.

Test Plan:
1. Release reset, imem_req_ready=1, 1-cycle response latency, if_ready=1 -> requests at 0x0, 0x4, 0x8; if_pc matches; if_pc_plus4 = 0x4, 0x8, 0xC.
2. ex_valid=1, ex_branch=1, ex_funct3=001, ex_zero=0, ex_pc=0x10, ex_imm_ext=0xFFFFFFF8 -> redirect=1, next imem_req_addr=0x08. Same with ex_zero=1 -> redirect=0, sequential fetch continues.
3. BGEU (funct3=111) with ex_zero=1, ex_pc=0x20, imm=0x40 -> next addr 0x60. JALR with ex_alu_result=0x101 -> next addr 0x100.
4. Redirect to 0x200 one cycle after a request handshake, response 0xDEADBEEF arriving 3 cycles later -> if_valid stays 0, response dropped, next request addr=0x200.
5. if_ready=0 for 5 cycles while in HOLD -> if_valid/if_instr/if_pc held constant, no imem request issued. Redirect during HOLD -> if_valid=0 next cycle.
6. Assert rst_n=0 while in WAIT -> all outputs return to reset values immediately. After release, the first request address equals RESET_PC.
